user_auth_ctrl: RTL and testbench

Parametrised user-authentication controller that replaces the fixed 7-entry, 16-bit ID checker in the memory-tester flow.
- Scans an external user-ID ROM of N_USERS entries with configurable read latency and compares each entry against the entered ID.
- On a match, grants ROM or RAM access from a per-user status bit.
- Counts consecutive failed logins and locks out after MAX_FAIL failures.
- Sits between the keypad/ID entry logic and the ROM/RAM test engines.

---
 rtl/user_auth_pkg.sv | 27 ++
 rtl/user_rom_scanner.sv | 46 ++++
 rtl/user_auth_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_user_auth_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_auth_pkg.sv
// user_auth_pkg: state encoding, counter width helper and default
// parameter values shared by the user-authentication controller files.
`timescale 1ns/1ps
package user_auth_pkg;

    localparam int DEF_ID_W        = 16;
    localparam int DEF_N_USERS     = 7;
    localparam int DEF_ADDR_W      = 3;
    localparam int DEF_ROM_LAT     = 2;
    localparam int DEF_MAX_FAIL    = 3;
    localparam int DEF_TIMEOUT_CYC = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        COMPARE,
        SESSION,
        DENY,
        LOCKOUT
    } auth_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/user_rom_scanner.sv
// user_rom_scanner: steps the user-ID ROM address and waits out the ROM
// read latency before each comparison.
// Ports: clock, rst (sync, active low); scan_clr returns to entry 0,
// scan_wait counts latency, scan_next advances; rom_addr is registered;
// cmp_strobe marks the last wait cycle, last_entry marks entry N_USERS-1.
`timescale 1ns/1ps
module user_rom_scanner
    import user_auth_pkg::*;
#(
    parameter int N_USERS = DEF_N_USERS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              scan_clr,
    input  logic              scan_wait,
    input  logic              scan_next,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              cmp_strobe,
    output logic              last_entry
);

    localparam int LAT_W = cnt_w(ROM_LAT - 1);

    logic [LAT_W-1:0] lat_cnt;

    always_ff @(posedge clock) begin
        if (!rst) begin
            rom_addr <= '0;
            lat_cnt  <= '0;
        end else if (scan_clr) begin
            rom_addr <= '0;
            lat_cnt  <= '0;
        end else if (scan_next) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            lat_cnt  <= '0;
        end else if (scan_wait) begin
            lat_cnt  <= lat_cnt + LAT_W'(1);
        end
    end

    assign cmp_strobe = scan_wait && (lat_cnt == LAT_W'(ROM_LAT - 1));
    assign last_entry = (rom_addr == ADDR_W'(N_USERS - 1));

endmodule

// File: rtl/user_auth_ctrl.sv
// user_auth_ctrl: scans the user-ID ROM for the entered ID, grants ROM or
// RAM test access per user, and locks out after MAX_FAIL failed logins.
// Ports: clock, rst (sync, active low); entered, valid_bit, log_out,
// status, rom_data in; rom_addr, internal_id, rom_access, ram_access,
// green_led_user, red_led_user, busy, locked, fail_count, timeout_flag out.
// Optional: define SESSION_TIMEOUT_EN to end sessions after TIMEOUT_CYC.
`timescale 1ns/1ps
module user_auth_ctrl
    import user_auth_pkg::*;
#(
    parameter int ID_W     = DEF_ID_W,
    parameter int N_USERS  = DEF_N_USERS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ROM_LAT  = DEF_ROM_LAT,
    parameter int MAX_FAIL = DEF_MAX_FAIL
`ifdef SESSION_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [ID_W-1:0]              entered,
    input  logic                         valid_bit,
    input  logic                         log_out,
    input  logic [N_USERS-1:0]           status,
    input  logic [ID_W-1:0]              rom_data,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic [ADDR_W-1:0]            internal_id,
    output logic                         rom_access,
    output logic                         ram_access,
    output logic                         green_led_user,
    output logic                         red_led_user,
    output logic                         busy,
    output logic                         locked,
    output logic [cnt_w(MAX_FAIL)-1:0]   fail_count,
    output logic                         timeout_flag
);

    localparam int FW = cnt_w(MAX_FAIL);

    auth_state_e       state, state_d;
    logic [ADDR_W-1:0] id_d;
    logic              rom_acc_d, ram_acc_d;
    logic              green_d, red_d, busy_d, locked_d, tflag_d;
    logic [FW-1:0]     fail_d;
    logic              scan_next, cmp_strobe, last_entry;
    logic              sess_done;

    user_rom_scanner #(
        .N_USERS (N_USERS),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) u_scan (
        .clock      (clock),
        .rst        (rst),
        .scan_clr   (state_d == IDLE),
        .scan_wait  (state == WAIT),
        .scan_next  (scan_next),
        .rom_addr   (rom_addr),
        .cmp_strobe (cmp_strobe),
        .last_entry (last_entry)
    );

`ifdef SESSION_TIMEOUT_EN
    localparam int SESS_W = cnt_w(TIMEOUT_CYC - 1);

    logic [SESS_W-1:0] sess_cnt;

    // Held at zero outside SESSION, so it starts from zero on entry.
    always_ff @(posedge clock) begin
        if (!rst || state != SESSION)
            sess_cnt <= '0;
        else
            sess_cnt <= sess_cnt + SESS_W'(1);
    end

    assign sess_done = (state == SESSION) &&
                       (sess_cnt == SESS_W'(TIMEOUT_CYC - 1));
`else
    assign sess_done = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rst) begin
            state          <= IDLE;
            internal_id    <= '0;
            rom_access     <= 1'b0;
            ram_access     <= 1'b0;
            green_led_user <= 1'b0;
            red_led_user   <= 1'b0;
            busy           <= 1'b0;
            locked         <= 1'b0;
            fail_count     <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            state          <= state_d;
            internal_id    <= id_d;
            rom_access     <= rom_acc_d;
            ram_access     <= ram_acc_d;
            green_led_user <= green_d;
            red_led_user   <= red_d;
            busy           <= busy_d;
            locked         <= locked_d;
            fail_count     <= fail_d;
            timeout_flag   <= tflag_d;
        end
    end

    always_comb begin
        state_d   = state;
        id_d      = internal_id;
        rom_acc_d = rom_access;
        ram_acc_d = ram_access;
        green_d   = green_led_user;
        red_d     = red_led_user;
        busy_d    = busy;
        locked_d  = locked;
        fail_d    = fail_count;
        tflag_d   = 1'b0;
        scan_next = 1'b0;
        unique case (state)
            IDLE: begin
                id_d      = '0;
                rom_acc_d = 1'b0;
                ram_acc_d = 1'b0;
                green_d   = 1'b0;
                red_d     = 1'b0;
                busy_d    = 1'b0;
                locked_d  = 1'b0;
                if (valid_bit) begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                if (log_out) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cmp_strobe) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // Abort wins over a match landing in the same cycle.
                if (log_out) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (rom_data == entered) begin
                    state_d   = SESSION;
                    green_d   = 1'b1;
                    id_d      = rom_addr;
                    ram_acc_d = status[rom_addr];
                    rom_acc_d = !status[rom_addr];
                    fail_d    = '0;
                    busy_d    = 1'b0;
                end else if (last_entry) begin
                    busy_d = 1'b0;
                    red_d  = 1'b1;
                    fail_d = fail_count + FW'(1);
                    if (fail_d == FW'(MAX_FAIL)) begin
                        state_d  = LOCKOUT;
                        locked_d = 1'b1;
                    end else begin
                        state_d = DENY;
                    end
                end else begin
                    scan_next = 1'b1;
                    state_d   = WAIT;
                end
            end
            SESSION: begin
                if (log_out || sess_done) begin
                    state_d   = IDLE;
                    green_d   = 1'b0;
                    rom_acc_d = 1'b0;
                    ram_acc_d = 1'b0;
                    id_d      = '0;
                    tflag_d   = !log_out;
                end
            end
            DENY: begin
                if (log_out) begin
                    state_d = IDLE;
                    red_d   = 1'b0;
                end
            end
            LOCKOUT: begin
                red_d    = 1'b1;
                locked_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_user_auth_ctrl.sv
// tb_user_auth_ctrl: randomized and directed checks of user_auth_ctrl
// against an outcome-level model of the ID scan and lockout rules.
`timescale 1ns/1ps
module tb_user_auth_ctrl;

    localparam int IW  = 16;
    localparam int N   = 7;
    localparam int AW  = 3;
    localparam int LAT = 2;
    localparam int MF  = 3;
    localparam int FW  = 2;
    localparam int N2  = 12;
    localparam int AW2 = 4;
    localparam int LT2 = 4;

    logic clock = 1'b0;
    logic rst = 1'b0;
    always #5 clock = ~clock;

    logic [IW-1:0] entered, rom_data;
    logic          valid_bit = 1'b0, log_out = 1'b0;
    logic [N-1:0]  status = '0;
    logic [AW-1:0] rom_addr, internal_id;
    logic          rom_access, ram_access, green, red;
    logic          busy, locked, timeout_flag;
    logic [FW-1:0] fail_count;

    logic [IW-1:0] rom_mem [N];
    logic [IW-1:0] pipe [LAT];

    always @(posedge clock) begin
        pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data = pipe[LAT-1];

    user_auth_ctrl #(
        .ID_W(IW), .N_USERS(N), .ADDR_W(AW), .ROM_LAT(LAT), .MAX_FAIL(MF)
`ifdef SESSION_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clock(clock), .rst(rst), .entered(entered),
        .valid_bit(valid_bit), .log_out(log_out), .status(status),
        .rom_data(rom_data), .rom_addr(rom_addr),
        .internal_id(internal_id), .rom_access(rom_access),
        .ram_access(ram_access), .green_led_user(green),
        .red_led_user(red), .busy(busy), .locked(locked),
        .fail_count(fail_count), .timeout_flag(timeout_flag)
    );

    logic [IW-1:0]  e2, rd2;
    logic           v2 = 1'b0, lo2 = 1'b0;
    logic [N2-1:0]  st2 = '0;
    logic [AW2-1:0] ra2, id2;
    logic           racc2, macc2, g2, r2, b2, l2, tf2;
    logic [FW-1:0]  fc2;
    logic [IW-1:0]  rom_mem2 [N2];
    logic [IW-1:0]  pipe2 [LT2];

    always @(posedge clock) begin
        pipe2[0] <= rom_mem2[ra2];
        for (int i = 1; i < LT2; i++) pipe2[i] <= pipe2[i-1];
    end
    assign rd2 = pipe2[LT2-1];

    user_auth_ctrl #(
        .ID_W(IW), .N_USERS(N2), .ADDR_W(AW2), .ROM_LAT(LT2), .MAX_FAIL(MF)
    ) dut2 (
        .clock(clock), .rst(rst), .entered(e2),
        .valid_bit(v2), .log_out(lo2), .status(st2),
        .rom_data(rd2), .rom_addr(ra2),
        .internal_id(id2), .rom_access(racc2),
        .ram_access(macc2), .green_led_user(g2),
        .red_led_user(r2), .busy(b2), .locked(l2),
        .fail_count(fc2), .timeout_flag(tf2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_fail = 0;

    // Outcome model: first matching entry, or none.
    function automatic void model(input logic [IW-1:0] id,
                                  output int k, output int cyc);
        k = -1;
        for (int i = 0; i < N; i++)
            if (k < 0 && rom_mem[i] == id) k = i;
        cyc = (k < 0) ? N * (LAT + 1) : (k + 1) * (LAT + 1);
    endfunction

    function automatic logic [14:0] all_out();
        return {rom_addr, internal_id, rom_access, ram_access, green, red,
                busy, locked, fail_count, timeout_flag};
    endfunction

    task automatic set_plan_rom();
        for (int i = 0; i < N; i++) rom_mem[i] = IW'((i + 1) * 16'h1111);
    endtask

    task automatic do_login(input logic [IW-1:0] id, output int cyc);
        entered = id;
        valid_bit = 1'b1;
        @(posedge clock); #1 valid_bit = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (green || red) break;
        end
        n_cmp++;
        if (!(green || red)) begin
            n_bad++;
            $display("FAIL login_done: no result after %0d cycles", cyc);
        end
    endtask

    task automatic do_logout();
        log_out = 1'b1;
        @(posedge clock); #1 log_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clock); #1 rst = 1'b1;
        m_fail = 0;
        n_cmp++;
        if (all_out() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out());
        end
    endtask

    task automatic test_grant_ram();
        int c;
        set_plan_rom();
        status = 7'b0000100;
        do_login(16'h3333, c);
        n_cmp++;
        if (c !== 9) begin
            n_bad++;
            $display("FAIL grant_latency: got %0d want 9", c);
        end
        n_cmp++;
        if ({green, red, ram_access, rom_access, internal_id, busy}
            !== {4'b1010, 3'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL grant_outputs: g%b r%b ram%b rom%b id%0d b%b",
                     green, red, ram_access, rom_access, internal_id, busy);
        end
        do_logout();
        n_cmp++;
        if (all_out() !== '0) begin
            n_bad++;
            $display("FAIL logout_clear: got %h want 0", all_out());
        end
    endtask

    task automatic test_rom_access();
        int c;
        status = 7'b1111110;
        do_login(16'h1111, c);
        n_cmp++;
        if (c !== 3 || {rom_access, ram_access, internal_id} !== 5'b10000)
        begin
            n_bad++;
            $display("FAIL rom_grant: cyc %0d rom%b ram%b id%0d want 3 1 0 0",
                     c, rom_access, ram_access, internal_id);
        end
        do_logout();
    endtask

    task automatic test_lockout();
        int c;
        for (int t = 1; t <= MF; t++) begin
            do_login(16'hDEAD, c);
            n_cmp++;
            if (c !== 21 || fail_count !== FW'(t) || !red || green
                || locked !== (t == MF)) begin
                n_bad++;
                $display("FAIL deny_%0d: cyc %0d fc %0d r%b g%b lk%b",
                         t, c, fail_count, red, green, locked);
            end
            if (t < MF) do_logout();
        end
        valid_bit = 1'b1;
        log_out = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        valid_bit = 1'b0;
        log_out = 1'b0;
        n_cmp++;
        if ({locked, red, green, busy, fail_count} !== {4'b1100, FW'(MF)})
        begin
            n_bad++;
            $display("FAIL lock_hold: lk%b r%b g%b b%b fc%0d want 1 1 0 0 3",
                     locked, red, green, busy, fail_count);
        end
        test_reset();
    endtask

    task automatic test_fail_recover();
        int c;
        for (int t = 1; t <= 2; t++) begin
            do_login(16'hBEEF, c);
            do_logout();
        end
        n_cmp++;
        if (fail_count !== 2'd2) begin
            n_bad++;
            $display("FAIL two_miss: fc got %0d want 2", fail_count);
        end
        do_login(16'h5555, c);
        n_cmp++;
        if (c !== 15 || fail_count !== 2'd0 || !green) begin
            n_bad++;
            $display("FAIL recover: cyc %0d fc %0d g%b want 15 0 1",
                     c, fail_count, green);
        end
        do_logout();
        m_fail = 0;
    endtask

    task automatic test_abort();
        int c;
        for (int t = 0; t < 5; t++) begin
            c = (t == 0) ? 5 : (t == 1) ? 3 : (t == 2) ? N * (LAT + 1)
                : int'($urandom_range(1, N * (LAT + 1)));
            entered = (t == 1) ? rom_mem[0] : 16'hDEAD;
            valid_bit = 1'b1;
            @(posedge clock); #1 valid_bit = 1'b0;
            repeat (c - 1) @(posedge clock);
            #1;
            n_cmp++;
            if ({busy, red, green} !== 3'b100) begin
                n_bad++;
                $display("FAIL scan_busy_%0d: b%b r%b g%b want 1 0 0",
                         t, busy, red, green);
            end
            log_out = 1'b1;
            @(posedge clock); #1 log_out = 1'b0;
            n_cmp++;
            if ({busy, red, green, rom_addr} !== 6'b0
                || fail_count !== FW'(m_fail)) begin
                n_bad++;
                $display("FAIL abort_%0d at %0d: b%b r%b g%b a%0d fc%0d",
                         t, c, busy, red, green, rom_addr, fail_count);
            end
        end
    endtask

    task automatic test_random();
        int k, ec, c;
        logic [IW-1:0] id;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++)
                rom_mem[i] = IW'($urandom_range(0, 9));
            status = N'($urandom);
            id = IW'($urandom_range(0, 9));
            model(id, k, ec);
            do_login(id, c);
            n_cmp++;
            if (c !== ec) begin
                n_bad++;
                $display("FAIL rand_lat_%0d: got %0d want %0d", it, c, ec);
            end
            if (k >= 0) begin
                m_fail = 0;
                n_cmp++;
                if ({green, red, ram_access, rom_access, internal_id}
                    !== {2'b10, status[k], !status[k], AW'(k)}) begin
                    n_bad++;
                    $display("FAIL rand_grant_%0d: g%b r%b ram%b rom%b id%0d k%0d",
                             it, green, red, ram_access, rom_access,
                             internal_id, k);
                end
            end else begin
                m_fail++;
                n_cmp++;
                if ({green, red, locked} !== {2'b01, m_fail == MF}) begin
                    n_bad++;
                    $display("FAIL rand_deny_%0d: g%b r%b lk%b want lk%b",
                             it, green, red, locked, m_fail == MF);
                end
            end
            n_cmp++;
            if (fail_count !== FW'(m_fail)) begin
                n_bad++;
                $display("FAIL rand_fc_%0d: got %0d want %0d",
                         it, fail_count, m_fail);
            end
            if (m_fail == MF) test_reset();
            else do_logout();
        end
    endtask

    task automatic test_session();
        int c;
        logic tf_seen, lost;
        set_plan_rom();
        do_login(16'h2222, c);
`ifdef SESSION_TIMEOUT_EN
        c = 0;
        while (c < 40 && green) begin
            @(posedge clock); #1;
            c++;
        end
        n_cmp++;
        if (c !== 16 || timeout_flag !== 1'b1 || ram_access || rom_access)
        begin
            n_bad++;
            $display("FAIL timeout: after %0d tf%b want 16 1", c, timeout_flag);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (timeout_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL tflag_pulse: got %b want 0", timeout_flag);
        end
        do_login(16'h2222, c);
        repeat (15) @(posedge clock);
        #1 log_out = 1'b1;
        @(posedge clock); #1 log_out = 1'b0;
        n_cmp++;
        if ({green, timeout_flag} !== 2'b00) begin
            n_bad++;
            $display("FAIL logout_at_timeout: g%b tf%b want 0 0",
                     green, timeout_flag);
        end
`else
        tf_seen = 1'b0;
        lost = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (timeout_flag) tf_seen = 1'b1;
            if (!green) lost = 1'b1;
        end
        n_cmp++;
        if ({tf_seen, lost} !== 2'b00) begin
            n_bad++;
            $display("FAIL no_timeout: tf%b lost%b want 0 0", tf_seen, lost);
        end
        do_logout();
`endif
    endtask

    task automatic test_big();
        int c;
        for (int i = 0; i < N2; i++) rom_mem2[i] = IW'(16'h0100 + i);
        st2 = 12'h800;
        e2 = rom_mem2[11];
        v2 = 1'b1;
        @(posedge clock); #1 v2 = 1'b0;
        c = 0;
        while (c < 200 && !g2 && !r2) begin
            @(posedge clock); #1;
            c++;
        end
        n_cmp++;
        if (c !== 60 || !g2 || id2 !== 4'd11 || !macc2 || racc2) begin
            n_bad++;
            $display("FAIL big_grant: cyc %0d g%b id%0d ram%b rom%b want 60",
                     c, g2, id2, macc2, racc2);
        end
        lo2 = 1'b1;
        @(posedge clock); #1 lo2 = 1'b0;
        v2 = 1'b1;
        @(posedge clock); #1 v2 = 1'b0;
        repeat (10) @(posedge clock);
        #1 rst = 1'b0;
        @(posedge clock); #1 rst = 1'b1;
        m_fail = 0;
        n_cmp++;
        if ({ra2, id2, racc2, macc2, g2, r2, b2, l2, fc2, tf2} !== '0
            || all_out() !== '0) begin
            n_bad++;
            $display("FAIL midscan_reset: a%0d b%b g%b dut1 %h",
                     ra2, b2, g2, all_out());
        end
    endtask

    initial begin
        entered = '0;
        e2 = '0;
        set_plan_rom();
        for (int i = 0; i < N2; i++) rom_mem2[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_grant_ram();
        test_rom_access();
        test_lockout();
        test_fail_recover();
        test_abort();
        test_random();
        test_session();
        test_big();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
